// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: strobe-driven 128x8 data memory with posted write buffer.
// Optional macro DMEM_TRACE_EN adds rd_count/wr_count.  Rev 1.0
// ============================================================================
module dmem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [ADDR_W-1:0] line_number,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_out,
  output logic              rd_valid,
  output logic              busy,
`ifdef DMEM_TRACE_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic              err_collision
);

  localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT - 1);
  localparam logic [2:0] WR_CNT_INIT = 3'(WR_LAT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              collide;

  logic              mem_read_q, mem_write_q;
  logic              rise_r, rise_w;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wcnt;

  logic              commit_en;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rise_r = mem_read & ~mem_read_q;
  assign rise_w = mem_write & ~mem_write_q;
  assign busy   = (state_q == RD_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      mem_read_q  <= mem_read;
      mem_write_q <= mem_write;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rd_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_r && !rise_w) begin
          rd_addr_d = line_number;
          cnt_d     = RD_CNT_INIT;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous write, or a new read while one is in flight, is a protocol error.
  assign collide = rise_r && (rise_w || (state_q == RD_WAIT));

  // Pending buffer contents are newer than the array, so they win on a match.
  assign rd_data = (wb_valid && (wb_addr == rd_addr_q)) ? wb_data : mem[rd_addr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      rd_addr_q     <= '0;
      mem_out       <= '0;
      rd_valid      <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_valid  <= rd_done;
      if (rd_done) begin
        mem_out <= rd_data;
      end
      if (collide) begin
        err_collision <= 1'b1;
      end
    end
  end

  // Old entry leaves the buffer either by timing out or by being displaced.
  assign commit_en = wb_valid && (rise_w ? (wb_addr != line_number) : (wcnt == 3'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wcnt     <= 3'd0;
    end else if (rise_w) begin
      wb_valid <= 1'b1;
      wb_addr  <= line_number;
      wb_data  <= mem_in;
      wcnt     <= WR_CNT_INIT;
    end else if (wb_valid) begin
      if (wcnt == 3'd0) begin
        wb_valid <= 1'b0;
      end else begin
        wcnt <= wcnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[wb_addr] <= wb_data;
    end
  end

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      if (rd_done && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (rise_w && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory strobe protocol (memRead/memWrite pulses, 7-bit line number, 8-bit data).
- Holds the 128x8 data array and detects strobe rising edges.
- Serves reads after a fixed latency and posts writes through a one-entry write buffer with read-after-write forwarding.
- Flags protocol violations to the core and bench.

Parameters:
- DATA_W, 8, data width
- ADDR_W, 7, line-number width
- DEPTH, 128, array entries (2**ADDR_W)
- RD_LAT, 1, cycles from read-strobe detection to data valid (legal 1..4)
- WR_LAT, 2, cycles a posted write waits in the buffer before committing (legal 1..4)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous active-high reset
- mem_in  input  DATA_W  write data, sampled on the write-strobe rising-edge cycle
- line_number  input  ADDR_W  address, sampled on the strobe rising-edge cycle
- mem_read  input  1  read strobe, level; only a 0->1 transition starts a read
- mem_write  input  1  write strobe, level; only a 0->1 transition starts a write
- mem_out  output  DATA_W  read data, held until the next read completes
- rd_valid  output  1  one-cycle pulse when mem_out is updated
- busy  output  1  high while a read is in flight
- err_collision  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, any cycle, mid-operation included):
  - mem_out=0, rd_valid=0, busy=0, err_collision=0.
  - Strobe-history registers cleared to 0.
  - Pending write buffer discarded (valid=0).
  - Array contents untouched.
  - The cycle after reset deasserts, a strobe already high counts as a rising edge.
- Edge detect: rise_r = mem_read & ~mem_read_q; rise_w likewise. Held-high strobes never retrigger.
- FSM states IDLE, RD_WAIT:
  - IDLE + rise_r (no rise_w): latch addr; cnt=RD_LAT-1; busy=1; go RD_WAIT.
  - RD_WAIT, cnt!=0: cnt-1.
  - RD_WAIT, cnt==0: mem_out <= forwarded/array data; rd_valid=1 for that cycle; busy=0; go IDLE.
  - With RD_LAT=1, data appears on the edge after the detect edge.
- Read data source: if the write buffer is valid and its addr equals the read addr at the completion edge, return buffer data; else return the array.
- Write path (accepted in either state):
  - rise_w captures {addr, mem_in} into the buffer; valid=1; wcnt=WR_LAT-1.
  - wcnt decrements each cycle; at 0 the entry commits to the array and valid clears.
  - rise_w while the buffer is valid, same addr: data overwritten (merge), wcnt reloaded, no array write.
  - rise_w while the buffer is valid, different addr: old entry commits to the array that edge, new entry captured.
- Violations (err_collision set, stays set until rst):
  - rise_r and rise_w on the same edge: the write is performed and the read is dropped.
  - rise_r while in RD_WAIT: ignored; the current read completes unchanged.
- Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.
- Single array write port: at most one commit per cycle.

Optional Feature:
- Macro DMEM_TRACE_EN. When defined, two extra outputs are added:
  - rd_count[15:0]: increments on each rd_valid.
  - wr_count[15:0]: increments on each accepted rise_w, including merges.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset, then rise_w line 5 data 8'hA7, then rise_r line 5 next cycle (WR_LAT=2, data still buffered) -> rd_valid pulse 1 cycle later, mem_out=8'hA7 (forwarded); after 2 more cycles the array[5] hierarchical read shows 8'hA7.
- rise_w line 9=8'h11, then line 9=8'h22 one cycle later, then wait 4 cycles, read line 9 -> mem_out=8'h22; array[9] never held 8'h11.
- rise_w line 3=8'h01, then line 4=8'h02 next cycle -> array[3]=8'h01 on that edge; reads of 3 and 4 return 8'h01 and 8'h02.
- RD_LAT=3, mem_read held high 10 cycles on line 7 -> exactly one rd_valid, 3 edges after the detect edge, busy high for 3 cycles; err_collision stays 0.
- mem_read and mem_write rise together (line 2, data 8'h5C) -> err_collision=1, no rd_valid, later read of line 2 returns 8'h5C; err_collision cleared only by rst; rst asserted during RD_WAIT -> busy=0 immediately, no rd_valid.
- DMEM_TRACE_EN defined: 3 writes (one merge) and 2 reads -> wr_count=3, rd_count=2; rst -> both 0.
